// File: rtl/spi_4094_sequencer_pkg.sv
// Shared encodings and defaults for the 4094 serial-latch sequencer and its register-bank neighbours.
package spi_4094_sequencer_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_DIV   = 4;

    // Register-bank addresses seen by the write path that feeds this block.
    localparam logic [7:0] REG_ADDR_CTRL = 8'h00;
    localparam logic [7:0] REG_ADDR_4094 = 8'h04;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SHIFT_LO = 2'd1,
        S_SHIFT_HI = 2'd2,
        S_STROBE   = 2'd3
    } state_e;

endpackage

// File: rtl/spi_4094_sequencer_clk_div_phase.sv
// Reloadable phase down-counter; tc is high while the count sits at zero.
// Latency: tc asserts DIV-1 cycles after reload (DIV cycles per phase).
// Backpressure: none; reload always wins over the count.
module clk_div_phase #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tc
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] RELOAD_VAL = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/spi_4094_sequencer.sv
// Bit-bangs a WIDTH-bit word MSB-first into a 74HC4094 chain, strobes it, then enables outputs.
// Latency: busy rise to done pulse is (2*WIDTH+1)*DIV cycles; all pin outputs are registered.
// Backpressure: none; writes while busy park in a one-deep pending slot, last write wins.
module spi_4094_sequencer
    import spi_4094_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             o_clk,
    output logic             o_data,
    output logic             o_strobe,
    output logic             o_oe
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic o_clk_q, o_clk_d;
    logic o_data_q, o_data_d;
    logic o_strobe_q, o_strobe_d;
    logic o_oe_q, o_oe_d;

    logic phase_tc;
    logic phase_reload;
    logic strobe_exit;

    // Every state entry restarts the half-period timer.
    assign phase_reload = (state_d != state_q);
    assign strobe_exit  = (state_q == S_STROBE) && phase_tc;

    clk_div_phase #(
        .DIV (DIV)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .reload (phase_reload),
        .tc     (phase_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load) state_d = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (phase_tc) state_d = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (phase_tc) state_d = (bit_cnt_q == '0) ? S_STROBE : S_SHIFT_LO;
            end
            S_STROBE: begin
                if (phase_tc) state_d = (load || pending_q) ? S_SHIFT_LO : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d   = data_in;
                    bit_cnt_d = LAST_BIT;
                end
            end
            S_SHIFT_HI: begin
                if (phase_tc && (bit_cnt_q != '0)) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                // A write landing on the exit cycle is newer than anything parked.
                if (phase_tc && load) begin
                    shift_d   = data_in;
                    bit_cnt_d = LAST_BIT;
                    pending_d = 1'b0;
                end else if (phase_tc && pending_q) begin
                    shift_d   = pend_q;
                    bit_cnt_d = LAST_BIT;
                    pending_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (load && (state_q != S_IDLE) && !strobe_exit) begin
            pend_d    = data_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        busy_d     = (state_d != S_IDLE);
        o_clk_d    = (state_d == S_SHIFT_HI);
        o_strobe_d = (state_d == S_STROBE);
        o_data_d   = 1'b0;
        if ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) begin
            o_data_d = shift_d[WIDTH-1];
        end
        done_d = strobe_exit;
        o_oe_d = o_oe_q | strobe_exit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            pend_q     <= '0;
            pending_q  <= 1'b0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            o_clk_q    <= 1'b0;
            o_data_q   <= 1'b0;
            o_strobe_q <= 1'b0;
            o_oe_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            pending_q  <= pending_d;
            bit_cnt_q  <= bit_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            o_clk_q    <= o_clk_d;
            o_data_q   <= o_data_d;
            o_strobe_q <= o_strobe_d;
            o_oe_q     <= o_oe_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign o_clk    = o_clk_q;
    assign o_data   = o_data_q;
    assign o_strobe = o_strobe_q;
    assign o_oe     = o_oe_q;

endmodule
